// File: rtl/and_or_arbiter_if.sv
// Bundles the two requester channels, the shared AND/OR unit connection and the
// tagged result channel of and_or_arbiter. The slave modport is the arbiter's view.
interface and_or_arbiter_if #(
    parameter int W = 4
);
    logic         req0Valid;
    logic         req0Ready;
    logic         req0Op;
    logic [W-1:0] req0A;
    logic [W-1:0] req0B;
    logic         req1Valid;
    logic         req1Ready;
    logic         req1Op;
    logic [W-1:0] req1A;
    logic [W-1:0] req1B;
    logic         uDoAnd;
    logic         uDoOr;
    logic [W-1:0] uAIn;
    logic [W-1:0] uBIn;
    logic [W-1:0] uOut;
    logic         uIsAnd;
    logic         resValid;
    logic         resReady;
    logic         resId;
    logic [W-1:0] resData;
    logic         errSticky;

    modport slave (
        input  req0Valid, req0Op, req0A, req0B,
        input  req1Valid, req1Op, req1A, req1B,
        input  uOut, uIsAnd, resReady,
        output req0Ready, req1Ready,
        output uDoAnd, uDoOr, uAIn, uBIn,
        output resValid, resId, resData, errSticky
    );

    modport master (
        output req0Valid, req0Op, req0A, req0B,
        output req1Valid, req1Op, req1A, req1B,
        output uOut, uIsAnd, resReady,
        input  req0Ready, req1Ready,
        input  uDoAnd, uDoOr, uAIn, uBIn,
        input  resValid, resId, resData, errSticky
    );
endinterface

// File: rtl/and_or_arbiter.sv
// Round-robin arbiter sharing one combinational AND/OR unit between two requesters.
// Optional grant statistics (grantCnt0/grantCnt1/statClr) under AND_OR_ARB_STATS_EN.
module and_or_arbiter #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef AND_OR_ARB_STATS_EN
    input  logic             statClr,
    output logic [CNT_W-1:0] grantCnt0,
    output logic [CNT_W-1:0] grantCnt1,
`endif
    and_or_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         grant0_s;
    logic         grant1_s;
    logic         op_s;
    logic [W-1:0] a_s;
    logic [W-1:0] b_s;

    logic         last_grant_q;
    logic         op_q;
    logic         id_q;
    logic         u_do_and_q;
    logic         u_do_or_q;
    logic [W-1:0] u_a_q;
    logic [W-1:0] u_b_q;
    logic         res_valid_q;
    logic         res_id_q;
    logic [W-1:0] res_data_q;
    logic         err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant selection and operand mux
    always_comb begin
        state_d  = state_q;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0Valid && bus.req1Valid) begin
                    // Both pending: the one not served last time wins
                    grant0_s = last_grant_q;
                    grant1_s = !last_grant_q;
                end else begin
                    grant0_s = bus.req0Valid;
                    grant1_s = bus.req1Valid;
                end
                if (grant0_s || grant1_s) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                if (bus.resReady) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant1_s) begin
            op_s = bus.req1Op;
            a_s  = bus.req1A;
            b_s  = bus.req1B;
        end else begin
            op_s = bus.req0Op;
            a_s  = bus.req0A;
            b_s  = bus.req0B;
        end
    end

    // Issue registers, unit drive, result capture and mismatch flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            op_q         <= 1'b0;
            id_q         <= 1'b0;
            u_do_and_q   <= 1'b0;
            u_do_or_q    <= 1'b0;
            u_a_q        <= {W{1'b0}};
            u_b_q        <= {W{1'b0}};
            res_valid_q  <= 1'b0;
            res_id_q     <= 1'b0;
            res_data_q   <= {W{1'b0}};
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0_s || grant1_s) begin
                        op_q         <= op_s;
                        id_q         <= grant1_s;
                        last_grant_q <= grant1_s;
                        u_do_and_q   <= !op_s;
                        u_do_or_q    <= op_s;
                        u_a_q        <= a_s;
                        u_b_q        <= b_s;
                    end
                end
                ISSUE: begin
                    res_data_q  <= bus.uOut;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    // Unit is idled again so it outputs zero outside ISSUE
                    u_do_and_q  <= 1'b0;
                    u_do_or_q   <= 1'b0;
                    u_a_q       <= {W{1'b0}};
                    u_b_q       <= {W{1'b0}};
                    if (bus.uIsAnd != !op_q) begin
                        err_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resReady) begin
                        res_valid_q <= 1'b0;
                    end
                end
                default: res_valid_q <= 1'b0;
            endcase
        end
    end

    assign bus.req0Ready = grant0_s;
    assign bus.req1Ready = grant1_s;
    assign bus.uDoAnd    = u_do_and_q;
    assign bus.uDoOr     = u_do_or_q;
    assign bus.uAIn      = u_a_q;
    assign bus.uBIn      = u_b_q;
    assign bus.resValid  = res_valid_q;
    assign bus.resId     = res_id_q;
    assign bus.resData   = res_data_q;
    assign bus.errSticky = err_q;

`ifdef AND_OR_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Saturating grant counters; clear takes priority over a same-cycle grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= {CNT_W{1'b0}};
            cnt1_q <= {CNT_W{1'b0}};
        end else if (statClr) begin
            cnt0_q <= {CNT_W{1'b0}};
            cnt1_q <= {CNT_W{1'b0}};
        end else begin
            if (grant0_s && (cnt0_q != {CNT_W{1'b1}})) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (grant1_s && (cnt1_q != {CNT_W{1'b1}})) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign grantCnt0 = cnt0_q;
    assign grantCnt1 = cnt1_q;
`endif

endmodule

// File: doc/and_or_arbiter.md
Name: and_or_arbiter

Overview:
- Shares one combinational 4-bit AND/OR unit between two requesters.
- Round-robin arbitration; valid/ready on requests, valid/ready on a single tagged result channel.
- Sits in front of the AND/OR datapath: drives its operand and op-select inputs, samples its result and its isAnd flag.

Parameters:
- W, 4, operand/result width; must match the shared unit.
- CNT_W, 8, width of grant counters; used only with AND_OR_ARB_STATS_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0Valid  in  1  requester 0 has an operation.
- req0Ready  out  1  requester 0 accepted this cycle.
- req0Op  in  1  0=AND, 1=OR.
- req0A, req0B  in  W  operands.
- req1Valid, req1Ready, req1Op, req1A, req1B: same for requester 1.
- uDoAnd, uDoOr  out  1  op select to the shared unit.
- uAIn, uBIn  out  W  operands to the shared unit.
- uOut  in  W  result from the shared unit.
- uIsAnd  in  1  op flag from the shared unit.
- resValid  out  1  result available.
- resReady  in  1  consumer takes the result.
- resId  out  1  requester that owns the result.
- resData  out  W  registered result.
- errSticky  out  1  uIsAnd mismatch seen; cleared only by reset.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, lastGrant=1 (so requester 0 wins first), resValid=0, resId=0, resData=0, errSticky=0, uDoAnd=uDoOr=0, uAIn=uBIn=0.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - reqNReady = grantN, combinational from the valids and lastGrant.
  - Only one requester valid: it is granted.
  - Both valid: the requester not equal to lastGrant is granted.
  - On grant: latch op, A, B and id into issue registers; update lastGrant; go to ISSUE.
  - No valid: stay in IDLE; both ready signals 0.
- ISSUE (exactly one cycle):
  - uDoAnd = !op, uDoOr = op; uAIn/uBIn = latched operands.
  - At clock edge: resData <= uOut, resId <= latched id, resValid <= 1; go to RESP.
  - If uIsAnd != !op at that edge: errSticky <= 1. Result still delivered.
- RESP:
  - resValid=1; resData and resId held stable until resReady.
  - resReady=1: resValid <= 0 and return to IDLE.
  - No new request is accepted in RESP. Both ready signals are 0 in ISSUE and RESP.
- Outside ISSUE: uDoAnd=uDoOr=0 and uAIn=uBIn=0, so the unit outputs 0 and no X propagates.
- Latency and throughput:
  - Grant at edge T; resValid high from T+2.
  - Minimum 3 cycles per operation with resReady held high.
- Inputs not in handshake: requester inputs are ignored unless that requester is granted in IDLE. A valid request must stay stable until its ready is seen.
- Reset mid-operation: the in-flight op and any pending result are dropped, no ready is produced, all outputs return to reset values immediately.

Optional Feature:
- Macro: AND_OR_ARB_STATS_EN.
- Defined:
  - Adds ports grantCnt0 and grantCnt1 (out, CNT_W) and statClr (in, 1).
  - Each counter increments on its requester's grant and saturates at all-ones.
  - statClr=1 synchronously zeroes both counters; clear wins over increment in the same cycle.
  - Reset value 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single op: req0Valid=1, Op=0, A=4'b1100, B=4'b1010, resReady=1 -> req0Ready pulses at T, resValid at T+2 with resId=0 and resData matching the shared unit's uOut for AND; uDoAnd=1 during T+1 only.
- Contention fairness: both valid continuously, req1Op=1 -> grant order 0,1,0,1; each grant 3 cycles apart; resId alternates.
- Backpressure: resReady=0 for 5 cycles after resValid -> resData and resId stable; no readyN asserted; op accepted in the cycle after resReady=1.
- Mismatch: force uIsAnd=1 during an OR issue -> errSticky=1 from the next cycle and stays set across later ops; result still delivered.
- Reset mid-op: drop rst_n during ISSUE -> resValid=0 and uDoOr=0 immediately; after release, req0 is granted first even if both are valid.
- Stats (AND_OR_ARB_STATS_EN, CNT_W=2): 5 grants to req0 -> grantCnt0 saturates at 3; statClr pulse -> 0.
